// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: a payload FIFO feeding a header/payload/parity serialiser.
// One byte per cycle while busy is low; busy freezes the presented byte and pkt_valid.
module router_pkt_tx #(
    parameter int DEPTH = 64,
    parameter int GAP   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic [6:0] fifo_count,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    output logic       ready,
    output logic       start_err,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] tx_data,
    output logic       done
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_PAR, S_GAP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   count;
    logic [5:0]    remain;
    logic [7:0]    parity;
    logic [GW-1:0] gap_cnt;
    logic          full;
    logic          push;
    logic          pop;
    logic          bad_req;

    assign full       = (count == (AW+1)'(DEPTH));
    assign push       = wr_en && !full;
    assign pop        = (state == S_PAY) && !busy;
    assign rd_nxt     = rd_ptr + 1'b1;
    assign fifo_full  = full;
    assign fifo_count = 7'(count);
    assign bad_req    = (pay_len == 6'd0) || (dest_addr == 2'd3) ||
                        (count < (AW+1)'(pay_len));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            start_err <= 1'b0;
            done      <= 1'b0;
            pkt_valid <= 1'b0;
            tx_data   <= 8'd0;
            parity    <= 8'd0;
            remain    <= 6'd0;
            gap_cnt   <= '0;
        end else begin
            start_err <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (bad_req) begin
                            start_err <= 1'b1;
                        end else begin
                            state     <= S_HDR;
                            ready     <= 1'b0;
                            pkt_valid <= 1'b1;
                            tx_data   <= {pay_len, dest_addr};
                            parity    <= {pay_len, dest_addr};
                            remain    <= pay_len;
                        end
                    end
                end
                S_HDR: begin
                    if (!busy) begin
                        state   <= S_PAY;
                        tx_data <= mem[rd_ptr];
                    end
                end
                S_PAY: begin
                    // The next head is read one slot ahead because the pop lands on this same edge.
                    if (!busy) begin
                        parity <= parity ^ tx_data;
                        remain <= remain - 1'b1;
                        if (remain == 6'd1) begin
                            state     <= S_PAR;
                            pkt_valid <= 1'b0;
                            tx_data   <= parity ^ tx_data;
                        end else begin
                            tx_data <= mem[rd_nxt];
                        end
                    end
                end
                S_PAR: begin
                    if (!busy) begin
                        done    <= 1'b1;
                        tx_data <= 8'd0;
                        parity  <= 8'd0;
                        if (GAP == 0) begin
                            state <= S_IDLE;
                            ready <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP - 1)) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
